input_pack_mem: RTL and testbench
=================================

INPUT_PACK_MEM -- requirements
Module: input_pack_mem

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 19200, SHALL set the number of 128-bit words per frame.
REQ-002 Parameter BYTES_PER_WORD, default 16, SHALL set the bytes packed per word; it is fixed at 16.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level-held frame enable; low SHALL abort and re-arm.
REQ-006 DataIn  input  8  pixel byte stream.
REQ-007 DataValid  input  1  DataIn qualifier; one byte is accepted per cycle when high.
REQ-008 input_base_offset  input  1  frame buffer select, placed in address bit 15.
REQ-009 WriteBus  output  128  packed word to memory.
REQ-010 WriteAddress  output  16  word address for WriteBus.
REQ-011 WriteEnable  output  1  one-cycle memory write strobe.
REQ-012 done  output  1  frame complete, held high while start is high.

Function
REQ-013 States SHALL be IDLE, PACK and DONE.
REQ-014 IDLE behaviour:
- start low SHALL hold the FSM in IDLE.
- byte_count SHALL be 0 and word_count SHALL be 0.
- WriteEnable SHALL be 0.
- WriteAddress SHALL be {input_base_offset, 15'b0}.
REQ-015 IDLE->PACK SHALL occur on the first cycle with start high; input_base_offset SHALL be captured on that edge and held for the whole frame.
REQ-016 In PACK, a byte accepted at byte_count k SHALL be written to bits [8k+7:8k] of the assembly register, then byte_count SHALL increment; cycles with DataValid low SHALL change nothing.
REQ-017 When byte 15 is accepted:
- on the next cycle, WriteBus SHALL equal the full 16-byte word, including byte 15.
- WriteEnable SHALL be high for exactly that one cycle.
- WriteAddress SHALL equal {base, word_count[14:0]} during the strobe.
- byte_count SHALL wrap to 0.
REQ-018 WriteAddress[14:0] SHALL increment on the cycle after each strobe.
REQ-019 A byte arriving in the same cycle as WriteEnable SHALL be accepted into lane 0 of the next word, with no stall and no loss; the sustained rate is 1 byte per cycle.
REQ-020 When the strobe for word index WORDS_PER_FRAME-1 (19199) is issued:
- the FSM SHALL enter DONE.
- done SHALL rise on the cycle after that strobe.
- WriteAddress SHALL hold at 19199 and SHALL NOT wrap.
REQ-021 In DONE:
- DataValid SHALL be ignored.
- no further WriteEnable SHALL be issued.
- done SHALL stay high until start falls.
REQ-022 start falling in any state SHALL return the FSM to IDLE on the next edge.
- A partially filled word SHALL be discarded and never written.
- done SHALL clear on that edge.
- A strobe already due (byte 15 accepted on the previous cycle) SHALL still be issued.
REQ-023 Address and counter widths:
- word_count SHALL be 15 bits; byte_count SHALL be 4 bits.
- Address arithmetic SHALL apply to bits [14:0] only; bit 15 SHALL never be altered by the increment.

Reset
REQ-024 reset_n low SHALL asynchronously force the following, regardless of start or any operation in progress:
- the FSM to IDLE.
- WriteBus, WriteAddress, WriteEnable and done to 0.
- byte_count, word_count and the assembly register to 0.
REQ-025 After reset_n deasserts, the block SHALL require start low or a fresh start high to begin a frame; no write SHALL occur before 16 new bytes are accepted.

Structure
REQ-026 A shared package SHALL hold:
- WORDS_PER_FRAME and BYTES_PER_WORD.
- the address width (16) and the base bit position (15).
- the state enum {IDLE, PACK, DONE}.
The output-side fetch block SHALL use the same package.
REQ-027 The 16-lane assembly register and lane-select decode SHALL be one sub-module, byte_lane_packer; the FSM, counters and address logic SHALL stay in input_pack_mem.

Verification
REQ-028 Single word: base=0, bytes 0x00..0x0F on 16 consecutive cycles -> one strobe; WriteBus=0x0F0E..0100; WriteAddress=0x0000.
REQ-029 Gapped input: the same 16 bytes with DataValid toggling 1,0,1,0 -> identical WriteBus; strobe one cycle after the last valid byte.
REQ-030 Back-to-back words with base=1, 32 continuous bytes -> strobes at WriteAddress 0x8000 then 0x8001; no byte lost at the word boundary.
REQ-031 Full frame: 19200*16 bytes -> last strobe at address 19199 (0x4AFF); done high the next cycle; extra bytes produce no strobe.
REQ-032 Abort: start drops after 7 bytes of word 3 -> no strobe for the partial word; a restart writes from address {base,0}.
REQ-033 Asynchronous reset asserted mid-word (byte_count=9) -> all outputs 0 immediately; next frame's first word is correct.

Source files
------------

// File: rtl/input_pack_mem_pkg.sv
// Shared constants and state type for the input packing path and the output-side fetch block.
package input_pack_mem_pkg;
    localparam int unsigned WORDS_PER_FRAME = 19200;
    localparam int unsigned BYTES_PER_WORD  = 16;
    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned BASE_BIT        = 15;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DONE
    } state_t;
endpackage

// File: rtl/input_pack_mem_byte_lane_packer.sv
// 16-lane byte assembly register with lane-select decode; o_word_next already carries the incoming byte.
module byte_lane_packer
    import input_pack_mem_pkg::*;
#(
    parameter int unsigned LANES  = BYTES_PER_WORD,
    parameter int unsigned LANE_W = $clog2(LANES)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [LANE_W-1:0]    i_lane,
    input  logic [7:0]           i_data,
    output logic [8*LANES-1:0]   o_word_next
);
    logic [8*LANES-1:0] r_asm;
    logic [8*LANES-1:0] w_next;

    always_comb begin
        w_next = r_asm;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i_load && (i_lane == LANE_W'(i))) begin
                w_next[8*i +: 8] = i_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_asm <= '0;
        end else if (i_clear) begin
            r_asm <= '0;
        end else if (i_load) begin
            r_asm <= w_next;
        end
    end

    assign o_word_next = w_next;
endmodule

// File: rtl/input_pack_mem.sv
// Packs a byte stream into 128-bit words and writes one frame of them into a selectable frame buffer.
module input_pack_mem #(
    parameter int unsigned WORDS_PER_FRAME = input_pack_mem_pkg::WORDS_PER_FRAME,
    parameter int unsigned BYTES_PER_WORD  = input_pack_mem_pkg::BYTES_PER_WORD
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [7:0]                            DataIn,
    input  logic                                  DataValid,
    input  logic                                  input_base_offset,
    output logic [8*BYTES_PER_WORD-1:0]           WriteBus,
    output logic [input_pack_mem_pkg::ADDR_W-1:0] WriteAddress,
    output logic                                  WriteEnable,
    output logic                                  done
);
    import input_pack_mem_pkg::*;

    localparam int unsigned       LANE_W    = $clog2(BYTES_PER_WORD);
    localparam int unsigned       IDX_W     = BASE_BIT;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WORDS_PER_FRAME - 1);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [LANE_W-1:0]           r_byte_count;
    logic [IDX_W-1:0]            r_word_count;
    logic                        r_base;
    logic [ADDR_W-1:0]           r_addr;
    logic [8*BYTES_PER_WORD-1:0] r_bus;
    logic                        r_we;
    logic                        w_accept;
    logic                        w_word_done;
    logic                        w_clear;
    logic [8*BYTES_PER_WORD-1:0] w_word_next;

    assign w_accept    = (r_state == PACK) && start && DataValid;
    assign w_word_done = w_accept && (r_byte_count == LAST_LANE);
    assign w_clear     = (r_state != PACK) || !start;

    byte_lane_packer #(
        .LANES  (BYTES_PER_WORD),
        .LANE_W (LANE_W)
    ) u_packer (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_clear     (w_clear),
        .i_load      (w_accept),
        .i_lane      (r_byte_count),
        .i_data      (DataIn),
        .o_word_next (w_word_next)
    );

    // The frame ends on the strobe cycle of the last word, so done follows that strobe by one cycle.
    always_comb begin
        w_state_next = r_state;
        if (!start) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = PACK;
                PACK:    if (r_we && (r_word_count == LAST_WORD)) w_state_next = DONE;
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_byte_count <= '0;
            r_word_count <= '0;
            r_base       <= 1'b0;
            r_addr       <= '0;
            r_bus        <= '0;
            r_we         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_we    <= w_word_done;
            if (w_word_done) begin
                r_bus <= w_word_next;
            end

            if (w_clear) begin
                r_byte_count <= '0;
            end else if (w_accept) begin
                r_byte_count <= r_byte_count + LANE_W'(1);
            end

            // Only the word index advances; the buffer-select bit is never touched by the increment.
            case (r_state)
                IDLE: begin
                    r_base       <= input_base_offset;
                    r_word_count <= '0;
                    r_addr       <= {input_base_offset, {IDX_W{1'b0}}};
                end
                PACK: begin
                    if (r_we && (r_word_count != LAST_WORD)) begin
                        r_word_count         <= r_word_count + IDX_W'(1);
                        r_addr[IDX_W-1:0]    <= r_word_count + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign WriteBus     = r_bus;
    assign WriteAddress = r_addr;
    assign WriteEnable  = r_we;
    assign done         = (r_state == DONE);
endmodule

// File: tb/tb_input_pack_mem.sv
// Randomized and directed bench for input_pack_mem against a byte-queue frame model.
module tb_input_pack_mem;
    localparam int unsigned N = 6;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   DataIn = 8'h00;
    logic         DataValid = 1'b0;
    logic         input_base_offset = 1'b0;
    logic [127:0] WriteBus;
    logic [15:0]  WriteAddress;
    logic         WriteEnable;
    logic         done;

    input_pack_mem #(
        .WORDS_PER_FRAME (N),
        .BYTES_PER_WORD  (16)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .DataIn            (DataIn),
        .DataValid         (DataValid),
        .input_base_offset (input_base_offset),
        .WriteBus          (WriteBus),
        .WriteAddress      (WriteAddress),
        .WriteEnable       (WriteEnable),
        .done              (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Frame model: bytes collect in a queue; every 16 make one expected write.
    logic [7:0]   m_q[$];
    bit           m_active = 0;
    bit           m_fin = 0;
    logic         m_base = 1'b0;
    int           m_words = 0;
    logic         exp_we = 1'b0;
    logic         exp_done = 1'b0;
    logic [127:0] exp_bus = '0;
    logic [15:0]  exp_addr = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0;
            m_fin    = 0;
            m_q.delete();
            m_words  = 0;
            exp_we   = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_we = 1'b0;
            if (!start) begin
                m_active = 0;
                m_fin    = 0;
                m_q.delete();
                m_words  = 0;
            end else if (m_fin) begin
                m_fin = 1;
            end else if (!m_active) begin
                m_active = 1;
                m_base   = input_base_offset;
            end else if (m_words == N) begin
                m_active = 0;
                m_fin    = 1;
            end else if (DataValid) begin
                m_q.push_back(DataIn);
                if (m_q.size() == 16) begin
                    for (int i = 0; i < 16; i++) exp_bus[8*i +: 8] = m_q[i];
                    exp_addr = {m_base, 15'(m_words)};
                    exp_we   = 1'b1;
                    m_words++;
                    m_q.delete();
                end
            end
            exp_done = m_fin;
        end
    end

    logic [127:0] log_bus[$];
    logic [15:0]  log_addr[$];
    bit           run_checks = 0;

    always @(negedge clock) begin
        if (run_checks) begin
            if (!reset_n) begin
                chk("rst_bus", WriteBus, 128'h0);
                chk("rst_addr", {112'h0, WriteAddress}, 128'h0);
                chk("rst_we", {127'h0, WriteEnable}, 128'h0);
                chk("rst_done", {127'h0, done}, 128'h0);
            end else begin
                chk("we", {127'h0, WriteEnable}, {127'h0, exp_we});
                chk("done", {127'h0, done}, {127'h0, exp_done});
                if (exp_we) begin
                    chk("bus", WriteBus, exp_bus);
                    chk("addr", {112'h0, WriteAddress}, {112'h0, exp_addr});
                end
                if (WriteEnable) begin
                    log_bus.push_back(WriteBus);
                    log_addr.push_back(WriteAddress);
                end
            end
        end
    end

    function automatic logic [127:0] lbus(input int i);
        if (i < log_bus.size()) return log_bus[i];
        return 'x;
    endfunction

    function automatic logic [127:0] laddr(input int i);
        if (i < log_addr.size()) return {112'h0, log_addr[i]};
        return 'x;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        DataValid = 1'b1;
        DataIn    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            DataValid = 1'b0;
        end
    endtask

    task automatic begin_frame(input logic base);
        @(negedge clock);
        start             = 1'b1;
        input_base_offset = base;
        DataValid         = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clock);
        start     = 1'b0;
        DataValid = 1'b0;
        idle(2);
        log_bus.delete();
        log_addr.delete();
    endtask

    initial begin
        int sent;
        repeat (2) @(negedge clock);
        run_checks = 1;
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // Single word, base 0
        begin_frame(1'b0);
        for (int i = 0; i < 16; i++) send(8'(i));
        idle(3);
        chk("single_cnt", 128'(log_bus.size()), 128'd1);
        chk("single_bus", lbus(0), 128'h0F0E0D0C0B0A09080706050403020100);
        chk("single_addr", laddr(0), 128'h0);
        end_frame();

        // Gapped input
        begin_frame(1'b0);
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            idle(1);
        end
        idle(2);
        chk("gap_cnt", 128'(log_bus.size()), 128'd1);
        chk("gap_bus", lbus(0), 128'h0F0E0D0C0B0A09080706050403020100);
        end_frame();

        // Back-to-back words, base 1
        begin_frame(1'b1);
        for (int i = 0; i < 32; i++) send(8'(8'h20 + i));
        idle(3);
        chk("b2b_cnt", 128'(log_bus.size()), 128'd2);
        chk("b2b_addr0", laddr(0), 128'h8000);
        chk("b2b_addr1", laddr(1), 128'h8001);
        chk("b2b_bus0", lbus(0), 128'h2F2E2D2C2B2A29282726252423222120);
        chk("b2b_bus1", lbus(1), 128'h3F3E3D3C3B3A39383736353433323130);
        end_frame();

        // Full frame plus extra bytes
        begin_frame(1'b0);
        sent = 0;
        for (int c = 0; c < 400 && sent < 16 * N + 10; c++) begin
            @(negedge clock);
            if ($urandom_range(9) < 7) begin
                DataValid = 1'b1;
                DataIn    = 8'($urandom);
                sent++;
            end else begin
                DataValid = 1'b0;
            end
        end
        idle(3);
        chk("frame_cnt", 128'(log_bus.size()), 128'(N));
        chk("frame_done", {127'h0, done}, 128'h1);
        chk("frame_addr_hold", {112'h0, WriteAddress}, 128'(N - 1));
        end_frame();

        // Abort mid word 3, then restart on base 1
        begin_frame(1'b0);
        for (int i = 0; i < 3 * 16 + 7; i++) send(8'($urandom));
        @(negedge clock);
        start     = 1'b0;
        DataValid = 1'b0;
        idle(1);
        begin_frame(1'b1);
        for (int i = 0; i < 16; i++) send(8'($urandom));
        idle(3);
        chk("abort_cnt", 128'(log_bus.size()), 128'd4);
        chk("abort_addr2", laddr(2), 128'h0002);
        chk("abort_restart_addr", laddr(3), 128'h8000);
        end_frame();

        // Asynchronous reset mid-word
        begin_frame(1'b0);
        for (int i = 0; i < 9; i++) send(8'(8'hA0 + i));
        @(negedge clock);
        DataValid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_bus", WriteBus, 128'h0);
        chk("async_addr", {112'h0, WriteAddress}, 128'h0);
        chk("async_we", {127'h0, WriteEnable}, 128'h0);
        chk("async_done", {127'h0, done}, 128'h0);
        @(negedge clock);
        reset_n = 1'b1;
        log_bus.delete();
        log_addr.delete();
        for (int i = 0; i < 16; i++) send(8'(8'hB0 + i));
        idle(3);
        chk("postrst_cnt", 128'(log_bus.size()), 128'd1);
        chk("postrst_bus", lbus(0), 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0);
        chk("postrst_addr", laddr(0), 128'h0);
        end_frame();

        // Random traffic with random aborts and base changes
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if ($urandom_range(249) == 0) start = ~start;
            input_base_offset = 1'($urandom);
            DataValid         = ($urandom_range(3) != 0);
            DataIn            = 8'($urandom);
        end
        end_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
